// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single register-file write port between two
//            writeback requesters (req0 = ALU, req1 = load unit) using
//            round-robin valid/ready arbitration. It also keeps a
//            per-register pending-write scoreboard so the issue stage can
//            detect RAW hazards.
// Ports    : clk, rst                   - clock, async active-high reset
//            req0_* / req1_*            - writeback requests (valid/ready,
//                                         rd, data)
//            issue_valid, issue_rd      - marks a destination pending
//            rs1_addr/rs2_addr          - source addresses to hazard-check
//            rs1_busy/rs2_busy/busy_vec - scoreboard outputs
//            we, rd_addr, rd_din        - registered register-file write port
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [AW-1:0]   req0_rd,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [AW-1:0]   req1_rd,
    input  logic [XLEN-1:0] req1_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [NREG-1:0] busy_vec,
    output logic            we,
    output logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_din
);

    localparam logic [AW-1:0] c_X0 = '0;

    logic            r_last_grant;   // 1'b0 = req0 won last, 1'b1 = req1
    logic            r_we;
    logic [AW-1:0]   r_rd_addr;
    logic [XLEN-1:0] r_rd_din;
    logic [NREG-1:0] r_busy;

    logic            w_grant0;
    logic            w_grant1;
    logic            w_accept;
    logic [AW-1:0]   w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic [NREG-1:0] w_busy_nxt;

    // Round-robin: on contention the requester that did not win last time
    // is served. Grants are masked during reset so nothing is handshaken
    // while state is being cleared.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst) begin
            w_grant0 = req0_valid && (!req1_valid || r_last_grant);
            w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign w_accept   = w_grant0 || w_grant1;
    assign w_sel_rd   = w_grant1 ? req1_rd   : req0_rd;
    assign w_sel_data = w_grant1 ? req1_data : req0_data;

    // Write port and arbitration history. rd_addr/rd_din hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_din     <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                r_last_grant <= w_grant1;
                r_we         <= (w_sel_rd != c_X0);
                r_rd_addr    <= w_sel_rd;
                r_rd_din     <= w_sel_data;
            end
        end
    end

    // Scoreboard next state: the clear (write committing this edge) is
    // applied first so that a same-index issue on the same edge overrides
    // it -- the newer producer is still outstanding.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_rd_addr] = 1'b0;
        end
        if (issue_valid && (issue_rd != c_X0)) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;
    assign rs1_busy = (rs1_addr != c_X0) && r_busy[rs1_addr];
    assign rs2_busy = (rs2_addr != c_X0) && r_busy[rs2_addr];
    assign we       = r_we;
    assign rd_addr  = r_rd_addr;
    assign rd_din   = r_rd_din;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_rd, req1_rd, issue_rd, rs1_addr, rs2_addr, rd_addr;
    logic [31:0] req0_data, req1_data, rd_din, busy_vec;
    logic        issue_valid, rs1_busy, rs2_busy, we;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rd(req0_rd), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rd(req1_rd), .req1_data(req1_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_vec(busy_vec),
        .we(we), .rd_addr(rd_addr), .rd_din(rd_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        int n0;
        int n1;
        rst = 1'b1;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'hAAAA0000;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h5555FFFF;
        issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
        tick(); tick();

        // Reset state, readys masked despite both valids high.
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
        chk("rst_addr", {27'd0, rd_addr}, 32'd0);
        chk("rst_din", rd_din, 32'd0);

        // Release: last_grant=1 after reset so req0 wins first.
        rst = 1'b0; settle();
        chk("first_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("first_rdy1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_rd = 5'd8; req0_data = 32'h10000000; settle();
        chk("w1_we", {31'd0, we}, 32'd1);
        chk("w1_addr", {27'd0, rd_addr}, 32'd3);
        chk("w1_din", rd_din, 32'hAAAA0000);
        chk("second_rdy1", {31'd0, req1_ready}, 32'd1);
        chk("second_rdy0", {31'd0, req0_ready}, 32'd0);
        tick();
        req1_rd = 5'd16; req1_data = 32'h20000000; settle();
        chk("w2_we", {31'd0, we}, 32'd1);
        chk("w2_addr", {27'd0, rd_addr}, 32'd4);
        chk("w2_din", rd_din, 32'h5555FFFF);

        // Sustained contention: grants alternate 0,1,0,1,0,1.
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            chk("alt_rdy0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_rdy1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("alt_we", {31'd0, we}, 32'd1);
            if (i % 2 == 0) begin
                chk("alt_addr0", {27'd0, rd_addr}, 32'd8 + n0);
                chk("alt_din0", rd_din, 32'h10000000 + n0);
                n0++;
                req0_rd = 5'(8 + n0); req0_data = 32'h10000000 + n0;
            end else begin
                chk("alt_addr1", {27'd0, rd_addr}, 32'd16 + n1);
                chk("alt_din1", rd_din, 32'h20000000 + n1);
                n1++;
                req1_rd = 5'(16 + n1); req1_data = 32'h20000000 + n1;
            end
            settle();
        end

        // Idle: no ready, we drops, address/data hold (last write was req1 rd=18).
        req0_valid = 1'b0; req1_valid = 1'b0; settle();
        chk("idle_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("idle_rdy1", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("idle_we", {31'd0, we}, 32'd0);
        chk("idle_addr", {27'd0, rd_addr}, 32'd18);
        chk("idle_din", rd_din, 32'h20000002);

        // Lone req1 is served every cycle despite winning last time.
        req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req1_rd = 5'(9 + i); req1_data = 32'hC0DE0000 + i; settle();
            chk("solo_rdy1", {31'd0, req1_ready}, 32'd1);
            tick();
            chk("solo_we", {31'd0, we}, 32'd1);
            chk("solo_addr", {27'd0, rd_addr}, 32'd9 + i);
        end
        req1_valid = 1'b0;

        // Write to x0: accepted, but no register-file write.
        req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'hDEADBEEF; settle();
        chk("x0_rdy0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("x0_we", {31'd0, we}, 32'd0);
        chk("x0_addr", {27'd0, rd_addr}, 32'd0);
        chk("x0_din", rd_din, 32'hDEADBEEF);
        chk("x0_busy", busy_vec, 32'd0);

        // Scoreboard set, hold through the write cycle, then clear.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd0; settle();
        chk("sb_set", busy_vec, 32'h00000080);
        chk("sb_rs1", {31'd0, rs1_busy}, 32'd1);
        chk("sb_rs2_x0", {31'd0, rs2_busy}, 32'd0);
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h00000077;
        tick();
        req0_valid = 1'b0;
        chk("sb_we7", {31'd0, we}, 32'd1);
        chk("sb_hold", busy_vec, 32'h00000080);
        tick();
        chk("sb_clr", busy_vec, 32'd0);
        chk("sb_rs1_clr", {31'd0, rs1_busy}, 32'd0);

        // Same-index set and clear on one edge: set wins.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd7; settle();
        chk("sw_we", {31'd0, we}, 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("sw_busy", busy_vec, 32'h00000080);

        // Build busy=0x88 with we=1, then async reset mid-cycle.
        issue_valid = 1'b1; issue_rd = 5'd3; req0_valid = 1'b1;
        tick();
        issue_valid = 1'b0; req0_valid = 1'b0; settle();
        chk("pre_busy", busy_vec, 32'h00000088);
        chk("pre_we", {31'd0, we}, 32'd1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("arst_we", {31'd0, we}, 32'd0);
        chk("arst_busy", busy_vec, 32'd0);
        chk("arst_addr", {27'd0, rd_addr}, 32'd0);
        chk("arst_din", rd_din, 32'd0);
        chk("arst_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("arst_rdy1", {31'd0, req1_ready}, 32'd0);
        tick();

        // After reset the round-robin pointer is back to favouring req0.
        rst = 1'b0; settle();
        chk("post_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("post_rdy1", {31'd0, req1_ready}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
